spi_slave_port: RTL
===================

Name: spi_slave_port

Overview:
Byte-oriented SPI slave endpoint consuming the master's spi_sclk/spi_mosi/spi_ss_n and returning spi_miso. It is the downstream stage on the SPI wire and the peer device for master-core loopback testing. All SPI inputs are oversampled in the system clock domain. It presents received bytes on a level valid/ack interface and takes response bytes through a single-entry TX holding register.

Parameters:
DATA_W, 8, bits per SPI frame (shift register and counter width).
CPOL, 0, idle level of spi_sclk.
CPHA, 0, 0 = sample on leading edge and shift on trailing edge; 1 = shift on leading edge and sample on trailing edge.
SYNC_STAGES, 2, flip-flop depth of input synchronizers (minimum 2).
FILL_BYTE, 8'hFF, value shifted out when the TX holding register is empty at frame start.

Ports:
clk  input  1  system clock; all logic is on its rising edge.
rst  input  1  asynchronous, active-high reset.
spi_sclk  input  1  serial clock from the master.
spi_mosi  input  1  serial data from the master.
spi_ss_n  input  1  active-low slave select.
spi_miso  output  1  serial data to the master.
spi_miso_oe  output  1  high while selected; the pad/top level tri-states when low.
tx_data  input  DATA_W  response byte.
tx_load  input  1  one-cycle strobe; writes tx_data into the holding register.
tx_empty  output  1  high when the holding register has no unsent byte.
rx_data  output  DATA_W  last received byte.
rx_valid  output  1  level; high while rx_data is unread.
rx_ack  input  1  consumer strobe; clears rx_valid and overrun.
overrun  output  1  sticky; a byte completed while rx_valid was high.
busy  output  1  high when the FSM is in ACTIVE.

Behaviour:
- Reset values: spi_miso=0, spi_miso_oe=0, tx_empty=1, rx_data=0, rx_valid=0, overrun=0, busy=0. The FSM resets to IDLE, the bit counter to 0, and the synchronizers to sclk=CPOL, ss_n=1, mosi=0.
- Input handling: spi_sclk, spi_mosi and spi_ss_n pass through SYNC_STAGES flip-flops. Edges are detected from the synchronized value against a one-cycle-delayed copy.
- Supported rate: spi_sclk must be at most clk/8. Faster rates are not supported.
- Edge mapping: leading edge is rising when CPOL=0 and falling when CPOL=1. The sample edge is the leading edge when CPHA=0, otherwise the trailing edge. The shift edge is the other edge.
- IDLE -> ACTIVE on a synchronized falling edge of ss_n. In the same clk:
  - the shift register loads the holding register (or FILL_BYTE if tx_empty=1);
  - tx_empty is set;
  - the bit counter clears;
  - spi_miso_oe=1, and spi_miso presents the MSB immediately. This is needed for CPHA=0.
- ACTIVE:
  - Each sample edge captures synchronized mosi into the RX shift register (MSB first) and increments the counter.
  - Each shift edge advances TX to the next bit. With CPHA=1, the first leading edge presents the MSB.
- Frame completion: on the DATA_W-th sample edge the counter wraps to 0.
  - If rx_valid=0, rx_data is updated and rx_valid rises on the next clk.
  - If rx_valid=1, the new byte is dropped, overrun is set and rx_data is unchanged.
  - The next frame's TX byte loads from the holding register (or FILL_BYTE) on the next shift edge. Back-to-back frames need no ss_n toggle.
- Latency: rx_valid rises SYNC_STAGES+2 clk after the final sample edge at the pin.
- ACTIVE -> IDLE on a synchronized rising edge of ss_n:
  - spi_miso_oe=0 and spi_miso=0;
  - a partial frame (counter != 0) is discarded with no rx_valid and no overrun.
- tx_load when tx_empty=1: tx_data is written and tx_empty clears.
- tx_load when tx_empty=0: the holding register is overwritten (last write wins).
- tx_load in the same cycle as a frame-start consume: the old contents are consumed, the new data is stored, and tx_empty=0.
- rx_ack clears rx_valid and overrun. If rx_ack coincides with a frame completion, the new byte is accepted and rx_valid stays 1.
- Asynchronous rst mid-frame returns everything to reset values immediately. The next frame begins only on a fresh ss_n falling edge.

Optional Feature:
SPI_SLAVE_LSB_FIRST_EN: when defined, TX and RX both shift LSB first and the first bit presented at frame start is bit 0. When undefined, frames are MSB first. Counter, handshakes and timing are identical in both builds.

Test Plan:
- Mode 0 (CPOL=0, CPHA=0), sclk=clk/16: tx_load 0x5A, then master sends 0xB6 -> rx_data=0xB6, rx_valid=1; master receives 0x5A; tx_empty=1 after ss_n falls.
- Mode 3 (CPOL=1, CPHA=1): same stimulus -> rx_data=0xB6 and master receives 0x5A.
- Two back-to-back frames with no second tx_load: master sends 0x11 then 0x22 under one ss_n low, acking after each -> rx sees 0x11 then 0x22; master receives 0x5A then 0xFF.
- Overrun: send 0x33 and 0x44 with no rx_ack -> rx_data=0x33, overrun=1. rx_ack -> rx_valid=0, overrun=0.
- Abort: ss_n deasserted after 5 bits of 0xC3 -> rx_valid stays 0, busy=0, spi_miso_oe=0. A following full 0x81 frame -> rx_data=0x81.
- rst pulse mid-frame at bit 3 -> all outputs at reset values. The subsequent 0xA5 frame is received correctly.

Source files
------------

// File: rtl/spi_slave_port.sv
// Byte-oriented SPI slave: oversampled SCLK/MOSI/SS_N, level valid/ack RX, single-entry TX holding register.
// Build option: define SPI_SLAVE_LSB_FIRST_EN to shift frames LSB first (default MSB first).
module spi_slave_port #(
  parameter int                DATA_W      = 8,
  parameter int                CPOL        = 0,
  parameter int                CPHA        = 0,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] FILL_BYTE   = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_ss_n,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_empty,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              overrun,
  output logic              busy
);

  localparam int   CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic SCLK_IDLE = (CPOL != 0);

  typedef enum logic {IDLE, ACTIVE} state_t;

  function automatic logic first_bit(input logic [DATA_W-1:0] v);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return v[0];
`else
    return v[DATA_W-1];
`endif
  endfunction

  function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] v);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return v >> 1;
`else
    return v << 1;
`endif
  endfunction

  function automatic logic [DATA_W-1:0] rx_insert(input logic [DATA_W-1:0] v, input logic b);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    return {b, v[DATA_W-1:1]};
`else
    return {v[DATA_W-2:0], b};
`endif
  endfunction

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, ss_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= {SYNC_STAGES{SCLK_IDLE}};
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= SCLK_IDLE;
      ss_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic ss_fall, ss_rise;

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s        = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise   = sclk_s & ~sclk_prev_q;
  assign sclk_fall   = ~sclk_s & sclk_prev_q;
  assign lead_edge   = SCLK_IDLE ? sclk_fall : sclk_rise;
  assign trail_edge  = SCLK_IDLE ? sclk_rise : sclk_fall;
  assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
  assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
  assign ss_fall     = ~ss_s & ss_prev_q;
  assign ss_rise     = ss_s & ~ss_prev_q;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              first_q, done_q;
  logic [DATA_W-1:0] tx_hold_q, tx_shift_q, rx_shift_q, rx_data_q;
  logic              tx_empty_q, rx_valid_q, overrun_q, miso_q, oe_q;

  logic [DATA_W-1:0] next_byte_d;
  logic              frame_start, reload, consume;

  assign next_byte_d = tx_empty_q ? FILL_BYTE : tx_hold_q;
  assign frame_start = (state_q == IDLE) && ss_fall;
  // The CPHA=1 first leading edge only re-presents the MSB already loaded at select.
  assign reload      = (state_q == ACTIVE) && !ss_rise && shift_edge && (cnt_q == '0) && !first_q;
  assign consume     = frame_start | reload;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      first_q    <= 1'b0;
      done_q     <= 1'b0;
      tx_hold_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      tx_empty_q <= 1'b1;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (tx_load) begin
        tx_hold_q  <= tx_data;
        tx_empty_q <= 1'b0;
      end else if (consume) begin
        tx_empty_q <= 1'b1;
      end

      if (rx_ack) begin
        rx_valid_q <= 1'b0;
        overrun_q  <= 1'b0;
      end
      if (done_q) begin
        if (!rx_valid_q || rx_ack) begin
          rx_data_q  <= rx_shift_q;
          rx_valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end

      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            state_q    <= ACTIVE;
            cnt_q      <= '0;
            first_q    <= 1'b1;
            oe_q       <= 1'b1;
            miso_q     <= first_bit(next_byte_d);
            tx_shift_q <= drop_bit(next_byte_d);
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            oe_q    <= 1'b0;
            miso_q  <= 1'b0;
          end else begin
            if (sample_edge) begin
              rx_shift_q <= rx_insert(rx_shift_q, mosi_s);
              if (cnt_q == CNT_W'(DATA_W - 1)) begin
                cnt_q  <= '0;
                done_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
            if (shift_edge) begin
              first_q <= 1'b0;
              if (reload) begin
                miso_q     <= first_bit(next_byte_d);
                tx_shift_q <= drop_bit(next_byte_d);
              end else if (cnt_q != '0) begin
                miso_q     <= first_bit(tx_shift_q);
                tx_shift_q <= drop_bit(tx_shift_q);
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign tx_empty    = tx_empty_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign overrun     = overrun_q;
  assign busy        = (state_q == ACTIVE);

endmodule
